// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder
// Circular byte FIFO in front of a UART transmitter. Application logic pushes
// bytes with wr_en; a two-state sequencer pops one byte at a time into the
// transmitter's tx_start/tx_din inputs and waits for tx_done_tick before the
// next launch. Writes arriving while the FIFO is full are dropped and flagged.

module uart_tx_fifo_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_accept;
    logic              pop;
    logic              start_next;

    // Occupancy flags come straight from the stored count, so a pop on the
    // same edge never makes room for a write that arrives while full.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign busy      = (state == ST_WAIT);
    assign wr_accept = wr_en && !full;

    // State register for the launch sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: launch from IDLE whenever bytes are waiting, then
    // park in WAIT until the transmitter reports the end of the stop bit.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Storage array; contents are left untouched by reset because the
    // pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy count and the registered transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
            tx_din   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                tx_din <= mem[rd_ptr];
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            tx_start <= start_next;
            overflow <= wr_en && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb_uart_tx_fifo_feeder
// Drives directed scenarios and a randomized phase into uart_tx_fifo_feeder,
// emulating the transmitter's tx_done_tick, and compares every output each
// cycle against a queue-based model of the feeder's behaviour.

module tb_uart_tx_fifo_feeder;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Transmitter emulation controls
    bit manual    = 0;
    bit tick_hold = 0;
    bit spur_en   = 0;
    int frame_len = 5;
    int cd        = 0;

    // Observation of launches and drops
    int         launches = 0;
    int         ovf_seen = 0;
    logic [7:0] seq[$];

    // Reference model state
    logic [7:0] q[$];
    bit         model_valid = 0;
    bit         in_flight   = 0;
    bit         m_start     = 0;
    logic [7:0] m_din       = 8'h00;
    bit         m_ovf       = 0;
    bit         m_acc;
    bit         m_pop;

    uart_tx_fifo_feeder #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .busy         (busy),
        .overflow     (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit we, input logic [7:0] data);
        wr_en   = we;
        wr_data = data;
        waitCycle();
    endtask

    task automatic drainFifo(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(empty === 1'b1 && busy === 1'b0)) begin
            waitCycle();
            n++;
        end
        waitCycle();
        checkOutput(name, {31'd0, (empty === 1'b1 && busy === 1'b0)}, 32'd1);
    endtask

    // Queue model: FIFO contents, one frame in flight, write refused when 16 stored
    always @(posedge clk) begin
        if (reset_n === 1'b0) begin
            q.delete();
            in_flight   = 0;
            m_start     = 0;
            m_din       = 8'h00;
            m_ovf       = 0;
            model_valid = 1;
        end else if (model_valid) begin
            m_acc = wr_en && (q.size() < 16);
            m_pop = !in_flight && (q.size() > 0);
            m_ovf = wr_en && !m_acc;
            if (in_flight) begin
                m_start = 0;
                if (tx_done_tick) in_flight = 0;
            end else if (m_pop) begin
                m_din     = q.pop_front();
                m_start   = 1;
                in_flight = 1;
            end else begin
                m_start = 0;
            end
            if (m_acc) q.push_back(wr_data);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("tx_start", {31'd0, tx_start}, {31'd0, m_start});
            checkOutput("tx_din",   {24'd0, tx_din},   {24'd0, m_din});
            checkOutput("count",    {27'd0, count},    q.size());
            checkOutput("full",     {31'd0, full},     {31'd0, (q.size() == 16)});
            checkOutput("empty",    {31'd0, empty},    {31'd0, (q.size() == 0)});
            checkOutput("busy",     {31'd0, busy},     {31'd0, in_flight});
            checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // Launch and drop recorder
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            launches++;
            seq.push_back(tx_din);
        end
        if (overflow === 1'b1) ovf_seen++;
    end

    // Transmitter emulation: tick frame_len cycles after each launch
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (manual) begin
                cd = 0;
            end else begin
                tx_done_tick = 1'b0;
                if (tx_start === 1'b1) begin
                    cd = frame_len;
                end else if (cd > 0) begin
                    if (!tick_hold) begin
                        cd--;
                        if (cd == 0) tx_done_tick = 1'b1;
                    end
                end else if (spur_en && busy === 1'b0 && $urandom_range(0, 7) == 0) begin
                    tx_done_tick = 1'b1;
                end
            end
        end
    end

    // Hard stop in case a scenario stalls
    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int saved;
        int wr_prob;
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_done_tick = 1'b0;

        repeat (2) waitCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_empty", {31'd0, empty}, 32'd1);
        checkOutput("reset_count", {27'd0, count}, 32'd0);
        checkOutput("reset_start", {31'd0, tx_start}, 32'd0);

        // Idle for 100 cycles without writes
        launches = 0;
        repeat (100) waitCycle();
        checkOutput("idle_no_launch", launches, 32'd0);

        // Single write of 0xA5, tick 50 cycles after launch
        frame_len = 50;
        applyStimulus(1'b1, 8'hA5);
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_start", {31'd0, tx_start}, 32'd1);
        checkOutput("single_din",   {24'd0, tx_din},   32'hA5);
        checkOutput("single_busy",  {31'd0, busy},     32'd1);
        repeat (60) waitCycle();
        checkOutput("single_busy_after", {31'd0, busy},  32'd0);
        checkOutput("single_empty_after", {31'd0, empty}, 32'd1);

        // Burst 0x00..0x0F on consecutive cycles
        frame_len = 4;
        launches  = 0;
        seq.delete();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i));
        wr_en = 1'b0;
        drainFifo("burst_drain");
        checkOutput("burst_launches", launches, 32'd16);
        for (int i = 0; i < seq.size(); i++) checkOutput("burst_order", {24'd0, seq[i]}, i);

        // Overflow: hold the first frame, write 20 bytes back to back
        tick_hold = 1;
        launches  = 0;
        ovf_seen  = 0;
        seq.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h40 + i));
        wr_en = 1'b0;
        waitCycle();
        checkOutput("ovf_pulses", ovf_seen, 32'd3);
        checkOutput("ovf_count",  {27'd0, count}, 32'd16);
        checkOutput("ovf_full",   {31'd0, full},  32'd1);
        tick_hold = 0;
        drainFifo("ovf_drain");
        checkOutput("ovf_launches", launches, 32'd17);
        for (int i = 0; i < seq.size(); i++) checkOutput("ovf_order", {24'd0, seq[i]}, 8'h40 + i);

        // Simultaneous write and pop with three bytes waiting
        manual       = 1;
        tx_done_tick = 1'b0;
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b1, 8'h33);
        applyStimulus(1'b1, 8'h44);
        wr_en = 1'b0;
        checkOutput("simul_pre_count", {27'd0, count}, 32'd3);
        tx_done_tick = 1'b1;
        waitCycle();
        tx_done_tick = 1'b0;
        applyStimulus(1'b1, 8'h99);
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("simul_count", {27'd0, count}, 32'd3);
        checkOutput("simul_start", {31'd0, tx_start}, 32'd1);
        checkOutput("simul_din",   {24'd0, tx_din},   32'h22);
        waitCycle();
        tx_done_tick = 1'b1;
        waitCycle();
        tx_done_tick = 1'b0;
        manual       = 0;
        frame_len    = 3;
        drainFifo("simul_drain");

        // Reset in the middle of a frame with five bytes pending
        manual = 1;
        tx_done_tick = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hC0 + i));
        wr_en = 1'b0;
        checkOutput("midrst_pre_count", {27'd0, count}, 32'd5);
        reset_n = 1'b0;
        waitCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_start", {31'd0, tx_start}, 32'd0);
        checkOutput("midrst_din",   {24'd0, tx_din},   32'd0);
        checkOutput("midrst_ovf",   {31'd0, overflow}, 32'd0);
        checkOutput("midrst_busy",  {31'd0, busy},     32'd0);
        checkOutput("midrst_empty", {31'd0, empty},    32'd1);
        checkOutput("midrst_full",  {31'd0, full},     32'd0);
        checkOutput("midrst_count", {27'd0, count},    32'd0);
        saved = launches;
        repeat (20) waitCycle();
        checkOutput("midrst_no_launch", launches, saved);
        manual = 0;

        // Randomized traffic with varying load, frame length and rare resets
        spur_en = 1;
        wr_prob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       wr_prob = 10;
                    1:       wr_prob = 50;
                    default: wr_prob = 90;
                endcase
            end
            frame_len = $urandom_range(1, 20);
            reset_n   = ($urandom_range(0, 599) != 0);
            wr_en     = ($urandom_range(0, 99) < wr_prob);
            wr_data   = 8'($urandom);
            waitCycle();
        end
        wr_en   = 1'b0;
        reset_n = 1'b1;
        spur_en = 0;
        drainFifo("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
